// File: rtl/cache_pkg.sv
// Types and constants shared by the caches, the RAM model and the memory arbiter.
package cache_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        IGRANT = 2'd1,
        DGRANT = 2'd2
    } arb_state_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    localparam logic [31:0] BAD_WORD = 32'hBAD1BAD1;

endpackage

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter between icache and dcache: data has priority, a
// saturating starvation counter forces an instruction grant after STARVE_LIMIT data grants.
//
//   state  | meaning
//   IDLE   | no owner; RAM enables low, both waits high, pick next winner
//   IGRANT | icache owns the RAM until ACCESS or iREN withdrawn
//   DGRANT | dcache owns the RAM until ACCESS or dREN/dWEN withdrawn
module mem_arbiter
    import cache_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        iREN,
    input  logic [31:0] iaddr,
    output logic        iwait,
    output logic [31:0] iload,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic        dwait,
    output logic [31:0] dload,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  logic [1:0]  ramstate
);

    localparam int              CW    = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0]   LIMIT = CW'(STARVE_LIMIT);

    arb_state_t    state;
    logic [CW-1:0] count;
    ramstate_t     rs;
    logic          dreq;
    logic          access;

    assign rs     = ramstate_t'(ramstate);
    assign access = (rs == ACCESS);
    assign dreq   = dREN | dWEN;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state <= IDLE;
            count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (dreq && iREN && (count == LIMIT))
                        state <= IGRANT;
                    else if (dreq)
                        state <= DGRANT;
                    else if (iREN)
                        state <= IGRANT;
                end
                IGRANT: begin
                    if (!iREN) begin
                        state <= IDLE;
                    end else if (access) begin
                        state <= IDLE;
                        count <= '0;
                    end
                end
                DGRANT: begin
                    if (!dreq) begin
                        state <= IDLE;
                    end else if (access) begin
                        state <= IDLE;
                        if (!iREN)
                            count <= '0;
                        else if (count != LIMIT)
                            count <= count + CW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Outputs follow the grant combinationally so a withdrawn request or an
    // ACCESS status takes effect in the same cycle, without an extra stage.
    always_comb begin
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        iwait    = 1'b1;
        dwait    = 1'b1;
        iload    = BAD_WORD;
        dload    = BAD_WORD;
        case (state)
            IGRANT: begin
                if (iREN) begin
                    ramREN  = 1'b1;
                    ramaddr = iaddr;
                    if (access) begin
                        iwait = 1'b0;
                        iload = ramload;
                    end
                end
            end
            DGRANT: begin
                if (dreq) begin
                    ramaddr = daddr;
                    if (dWEN) begin
                        ramWEN   = 1'b1;
                        ramstore = dstore;
                    end else begin
                        ramREN = 1'b1;
                    end
                    if (access) begin
                        dwait = 1'b0;
                        dload = ramload;
                    end
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter; the RAM status is driven by hand each cycle.
module tb_mem_arbiter;
    import cache_pkg::*;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        iREN, dREN, dWEN;
    logic [31:0] iaddr, daddr, dstore, ramload;
    logic [1:0]  ramstate;
    logic        iwait, dwait, ramREN, ramWEN;
    logic [31:0] iload, dload, ramaddr, ramstore;

    int n_cmp = 0;
    int n_err = 0;

    always #5 CLK = ~CLK;

    mem_arbiter #(.STARVE_LIMIT(4)) dut (
        .CLK(CLK), .nRST(nRST),
        .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dwait(dwait), .dload(dload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr),
        .ramstore(ramstore), .ramload(ramload), .ramstate(ramstate)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, " ramREN"}, 32'(ramREN), 32'd0);
        chk({tag, " ramWEN"}, 32'(ramWEN), 32'd0);
        chk({tag, " iwait"},  32'(iwait),  32'd1);
        chk({tag, " dwait"},  32'(dwait),  32'd1);
        chk({tag, " iload"},  iload, BAD_WORD);
        chk({tag, " dload"},  dload, BAD_WORD);
    endtask

    initial begin
        nRST = 1'b0; iREN = 0; dREN = 0; dWEN = 0;
        iaddr = 0; daddr = 0; dstore = 0; ramload = 0; ramstate = 2'(FREE);
        repeat (2) @(negedge CLK);
        #1 chk_idle("reset");
        @(negedge CLK); nRST = 1'b1;

        // single instruction fetch, ACCESS two cycles after enable
        @(negedge CLK); iREN = 1; iaddr = 32'h40;
        #1 chk("t1 arb ramREN", 32'(ramREN), 32'd0);
        @(negedge CLK); ramstate = 2'(BUSY);
        #1 chk("t1 c1 ramREN", 32'(ramREN), 32'd1);
        chk("t1 c1 ramaddr", ramaddr, 32'h40);
        chk("t1 c1 iwait", 32'(iwait), 32'd1);
        @(negedge CLK); ramstate = 2'(ACCESS); ramload = 32'h12345678;
        #1 chk("t1 acc iwait", 32'(iwait), 32'd0);
        chk("t1 acc iload", iload, 32'h12345678);
        chk("t1 acc dwait", 32'(dwait), 32'd1);
        chk("t1 acc dload", dload, BAD_WORD);
        @(negedge CLK); iREN = 0; ramstate = 2'(FREE);
        #1 chk_idle("t1 after");

        // simultaneous requests: data first, instruction after one IDLE
        @(negedge CLK); iREN = 1; iaddr = 32'h44; dREN = 1; daddr = 32'h200;
        #1 chk("t2 arb ramREN", 32'(ramREN), 32'd0);
        @(negedge CLK); ramstate = 2'(ACCESS); ramload = 32'hA5A5A5A5;
        #1 chk("t2 d ramaddr", ramaddr, 32'h200);
        chk("t2 d dwait", 32'(dwait), 32'd0);
        chk("t2 d dload", dload, 32'hA5A5A5A5);
        chk("t2 d iwait", 32'(iwait), 32'd1);
        chk("t2 d iload", iload, BAD_WORD);
        @(negedge CLK); dREN = 0; ramstate = 2'(FREE);
        #1 chk_idle("t2 bubble");
        @(negedge CLK); ramstate = 2'(ACCESS); ramload = 32'h11111111;
        #1 chk("t2 i ramaddr", ramaddr, 32'h44);
        chk("t2 i iwait", 32'(iwait), 32'd0);
        chk("t2 i iload", iload, 32'h11111111);
        @(negedge CLK); iREN = 0; ramstate = 2'(FREE);
        #1 chk_idle("t2 after");

        // write, with BUSY and ERROR held off and an address change passed through
        @(negedge CLK); dWEN = 1; daddr = 32'h100; dstore = 32'hDEADBEEF;
        #1 chk("t3 arb ramWEN", 32'(ramWEN), 32'd0);
        @(negedge CLK); ramstate = 2'(BUSY);
        #1 chk("t3 ramWEN", 32'(ramWEN), 32'd1);
        chk("t3 ramREN", 32'(ramREN), 32'd0);
        chk("t3 ramaddr", ramaddr, 32'h100);
        chk("t3 ramstore", ramstore, 32'hDEADBEEF);
        chk("t3 busy dwait", 32'(dwait), 32'd1);
        @(negedge CLK); ramstate = 2'(ERROR); daddr = 32'h104;
        #1 chk("t3 err dwait", 32'(dwait), 32'd1);
        chk("t3 err ramWEN", 32'(ramWEN), 32'd1);
        chk("t3 err ramaddr", ramaddr, 32'h104);
        @(negedge CLK); ramstate = 2'(ACCESS);
        #1 chk("t3 acc dwait", 32'(dwait), 32'd0);
        @(negedge CLK); dWEN = 0; ramstate = 2'(FREE);
        #1 chk_idle("t3 after");

        // starvation: four data grants, then the instruction grant
        @(negedge CLK); iREN = 1; iaddr = 32'h80; dREN = 1; daddr = 32'h300;
        for (int k = 0; k < 4; k++) begin
            ramstate = 2'(FREE);
            #1 chk($sformatf("t4 idle%0d ramREN", k), 32'(ramREN), 32'd0);
            @(negedge CLK); ramstate = 2'(ACCESS); ramload = 32'h300 + 32'(k);
            #1 chk($sformatf("t4 d%0d ramaddr", k), ramaddr, 32'h300);
            chk($sformatf("t4 d%0d dwait", k), 32'(dwait), 32'd0);
            chk($sformatf("t4 d%0d iwait", k), 32'(iwait), 32'd1);
            @(negedge CLK);
        end
        ramstate = 2'(FREE);
        #1 chk("t4 idle4 ramREN", 32'(ramREN), 32'd0);
        @(negedge CLK); ramstate = 2'(ACCESS); ramload = 32'h0BADCAFE;
        #1 chk("t4 i ramaddr", ramaddr, 32'h80);
        chk("t4 i iwait", 32'(iwait), 32'd0);
        chk("t4 i iload", iload, 32'h0BADCAFE);
        chk("t4 i dwait", 32'(dwait), 32'd1);
        @(negedge CLK); ramstate = 2'(FREE);
        #1 chk("t4 idle5 ramREN", 32'(ramREN), 32'd0);
        @(negedge CLK); ramstate = 2'(ACCESS);
        #1 chk("t4 cnt0 ramaddr", ramaddr, 32'h300);
        chk("t4 cnt0 dwait", 32'(dwait), 32'd0);
        @(negedge CLK); iREN = 0; dREN = 0; ramstate = 2'(FREE);
        #1 chk_idle("t4 after");

        // instruction request withdrawn before ACCESS
        @(negedge CLK); iREN = 1; iaddr = 32'h90;
        @(negedge CLK); ramstate = 2'(BUSY);
        #1 chk("t5 g ramREN", 32'(ramREN), 32'd1);
        @(negedge CLK); iREN = 0;
        #1 chk("t5 wd ramREN", 32'(ramREN), 32'd0);
        chk("t5 wd iwait", 32'(iwait), 32'd1);
        @(negedge CLK); dREN = 1; daddr = 32'h204; ramstate = 2'(FREE);
        #1 chk_idle("t5 idle");
        @(negedge CLK); ramstate = 2'(ACCESS); ramload = 32'h5A5A0001;
        #1 chk("t5 d ramREN", 32'(ramREN), 32'd1);
        chk("t5 d ramaddr", ramaddr, 32'h204);
        chk("t5 d dwait", 32'(dwait), 32'd0);
        chk("t5 d dload", dload, 32'h5A5A0001);
        @(negedge CLK); dREN = 0; ramstate = 2'(FREE);

        // asynchronous reset in the middle of a data grant
        @(negedge CLK); dWEN = 1; daddr = 32'h108; dstore = 32'hCAFEF00D;
        @(negedge CLK); ramstate = 2'(BUSY);
        #1 chk("t6 g ramWEN", 32'(ramWEN), 32'd1);
        #2 nRST = 1'b0;
        #1 chk_idle("t6 rst");
        @(negedge CLK); nRST = 1'b1; ramstate = 2'(FREE);
        #1 chk_idle("t6 rel");
        @(negedge CLK); ramstate = 2'(ACCESS);
        #1 chk("t6 re ramWEN", 32'(ramWEN), 32'd1);
        chk("t6 re ramaddr", ramaddr, 32'h108);
        chk("t6 re ramstore", ramstore, 32'hCAFEF00D);
        chk("t6 re dwait", 32'(dwait), 32'd0);
        @(negedge CLK); dWEN = 0; ramstate = 2'(FREE);
        #1 chk_idle("t6 after");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

- Arbitrates the single-ported RAM between the instruction cache (read-only) and the data cache (read/write); sits between the caches and the RAM model in the memory controller.
- Holds a registered grant for the duration of each word transfer and gives data requests priority.
- Uses a starvation counter so instruction fetch is guaranteed progress.
- Returns per-cache wait/load signals.

## Interface
- STARVE_LIMIT, 4: consecutive data grants allowed while an instruction request is pending.
- CLK  in  1  clock, rising edge.
- nRST  in  1  reset, asynchronous, active-low.
- iREN  in  1  icache read request.
- iaddr  in  32  icache word address.
- iwait  out  1  low in the cycle iload is valid.
- iload  out  32  instruction word to icache.
- dREN  in  1  dcache read request.
- dWEN  in  1  dcache write request.
- daddr  in  32  dcache word address.
- dstore  in  32  dcache write data.
- dwait  out  1  low in the cycle a dcache transfer completes.
- dload  out  32  data word to dcache.
- ramREN  out  1  RAM read enable.
- ramWEN  out  1  RAM write enable.
- ramaddr  out  32  RAM address.
- ramstore  out  32  RAM write data.
- ramload  in  32  RAM read data.
- ramstate  in  2  RAM status: FREE=0, BUSY=1, ACCESS=2, ERROR=3.

## Operation
- FSM states: IDLE, IGRANT, DGRANT; reset state is IDLE, starvation counter is 0.
- IDLE: all RAM enables low and both waits high.
  - Winner selection, in order:
    - If (dREN|dWEN), iREN is set and count==STARVE_LIMIT: go to IGRANT.
    - Otherwise, if (dREN|dWEN): go to DGRANT.
    - Otherwise, if iREN: go to IGRANT.
- IGRANT:
  - Outputs: ramREN=1, ramaddr=iaddr.
  - When ramstate==ACCESS: iwait=0, iload=ramload, next state IDLE.
  - On completion the counter clears to 0.
- DGRANT:
  - A write has precedence over a read: if dWEN, ramWEN=1 and ramstore=dstore; otherwise ramREN=1. ramaddr=daddr.
  - When ramstate==ACCESS: dwait=0, dload=ramload, next state IDLE.
  - On completion the counter increments, saturating at STARVE_LIMIT, only if iREN is high in that cycle; otherwise it clears.
- Request withdrawn while granted (owner's REN/WEN low before ACCESS): drop the RAM enables that cycle, keep the wait high, return to IDLE, leave the counter unchanged.
- Address or data changes while granted: passed straight through; the arbiter does not latch request payload.
- ramstate BUSY, FREE or ERROR while granted: the wait stays high and the grant is held (retry until ACCESS).
- Outputs of the non-owner: wait=1, load=32'hBAD1BAD1. iload and dload also read 32'hBAD1BAD1 in IDLE and on reset.
- Reset mid-transfer: asynchronously return to IDLE.
  - All RAM enables drop immediately and both waits read 1.
  - The counter clears to 0.

## Timing
- Grant is registered: a request seen in IDLE at edge N drives the RAM from cycle N+1.
- Minimum transfer cost:
  - 1 arbitration cycle, plus the RAM latency, plus completion in the ACCESS cycle.
  - Back-to-back requests from one cache incur one IDLE bubble each.
- The wait is combinational from ramstate in the granted state; there is no extra pipeline stage.
- Starvation bound: with continuous data traffic, an instruction request waits at most STARVE_LIMIT data transfers.

## Structure
- Shared package cache_pkg holds:
  - arb_state_t {IDLE, IGRANT, DGRANT};
  - ramstate_t;
  - the BAD word constant.
- ramstate_t and the BAD constant are shared with the caches and the RAM model.
- Single module, no sub-modules. The saturating counter is inline; it is $clog2(STARVE_LIMIT+1) bits wide.

## Test plan
- Reset, then iREN=1 with iaddr=0x40 and the RAM returning ACCESS 2 cycles after enable:
  - ramREN is high from cycle 1.
  - iwait drops exactly once, with iload equal to the RAM word.
  - The FSM is back in IDLE the following cycle.
- iREN and dREN both high at once:
  - DGRANT is served first and dwait drops first.
  - IGRANT follows after one IDLE cycle.
- dWEN=1 with daddr=0x100 and dstore=0xDEADBEEF: ramWEN=1, ramaddr=0x100, ramstore=0xDEADBEEF; dwait drops on ACCESS.
- Continuous dREN with iREN held high and STARVE_LIMIT=4: four data grants complete, then an instruction grant, then the counter is 0.
- iREN dropped after 1 granted cycle before ACCESS: ramREN falls the same cycle, iwait stays 1, the FSM goes to IDLE, and a later dREN is served normally.
- nRST asserted in mid-DGRANT while ramstate=BUSY: ramWEN/ramREN go to 0 immediately and dwait=1; after release a new request is arbitrated from IDLE.
